lsu_sequencer: RTL and testbench
================================

LSU_SEQUENCER -- requirements
Module: lsu_sequencer

Interface
REQ-001 Parameter: DATA_WIDTH, 32, data and address width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req_valid  input  1  load/store request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_mode  input  3  access mode; uses the shared W_MODE/H_MODE/UH_MODE/B_MODE/UB_MODE encodings.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-aligned.
REQ-009 req_we  input  1  1 = store, 0 = load.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load result, extended per mode; 0 for stores.
REQ-012 resp_split  output  1  completed access was split into byte beats.
REQ-013 mem_ls_mode  output  3  mode to the data-memory stage.
REQ-014 mem_a  output  32  address to the data-memory stage.
REQ-015 mem_wd  output  32  write data to the data-memory stage.
REQ-016 mem_we  output  1  write enable to the data-memory stage.
REQ-017 mem_rd  input  32  read data from the data-memory stage; valid within the same cycle as the beat.

Function
REQ-018 The FSM SHALL have three states: IDLE, BEAT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, a handshake (req_valid & req_ready) SHALL register mode, addr, wdata and we, clear the beat counter, set the beat count, and go to BEAT.
REQ-020 The access SHALL be misaligned when the mode is W_MODE with addr[1:0]!=0, or the mode is H_MODE/UH_MODE with addr[0]=1.
REQ-021 Beat count SHALL be 1 if aligned, 2 for a misaligned half, and 4 for a misaligned word.
REQ-022 An aligned beat SHALL drive mem_ls_mode=mode, mem_a=addr and mem_wd=wdata.
REQ-023 Misaligned beat k SHALL drive mem_ls_mode=UB_MODE and mem_a=addr+k (mod 2^32); mem_wd SHALL be wdata byte k replicated into all four lanes.
REQ-024 mem_we SHALL be asserted only in BEAT, and only when the registered we is 1.
REQ-025 Outside BEAT, mem_a and mem_ls_mode SHALL hold their registered values, and mem_we SHALL be 0.
REQ-026 Each BEAT cycle SHALL capture mem_rd on the rising edge; an aligned beat SHALL capture all 32 bits, and a split beat k SHALL capture mem_rd[7:0] into assembly byte k.
REQ-027 After the last beat the FSM SHALL go to RESP; RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE.
REQ-028 For a split word load, resp_rdata SHALL be {b3,b2,b1,b0}.
REQ-029 For a split half load, resp_rdata SHALL be {b1,b0} sign-extended for H_MODE and zero-extended for UH_MODE.
REQ-030 For an aligned load, resp_rdata SHALL equal the captured mem_rd unchanged, since extension is performed by the memory stage.
REQ-031 A store SHALL pulse resp_valid with resp_rdata=0.
REQ-032 resp_rdata and resp_split SHALL be held stable from RESP until the next RESP.
REQ-033 Latency SHALL be: handshake at cycle N, beats at N+1..N+k, resp_valid at N+k+1, and req_ready=1 again at N+k+2.
REQ-034 An unrecognised req_mode SHALL run a single beat with mem_we forced 0 and complete with resp_rdata=0.
REQ-035 req_valid asserted while not ready SHALL be ignored with no side effects; the requester holds it.

Reset
REQ-036 While rst_n=0 at a rising edge, the next state SHALL be IDLE.
REQ-037 Reset SHALL produce: req_ready=1, resp_valid=0, resp_rdata=0, resp_split=0, mem_we=0, mem_a=0, mem_wd=0, mem_ls_mode=0, and beat counter=0.
REQ-038 Reset in BEAT or RESP SHALL abandon the access: no further beats, and no resp_valid.

Verification
REQ-039 Aligned LW at 0x100, memory word 0xDEADBEEF -> 1 beat, resp_valid at N+2, rdata=0xDEADBEEF, resp_split=0.
REQ-040 SW 0x11223344 at 0x201 -> 4 UB beats at 0x201..0x204, mem_wd=0x44444444, 0x33333333, 0x22222222, 0x11111111; a following LW at 0x201 returns 0x11223344 with resp_split=1.
REQ-041 Bytes 0x303=0x80, 0x304=0xFF -> LH at 0x303: 2 beats, rdata=0xFFFFFF80; LHU at 0x303: rdata=0x0000FF80.
REQ-042 LW at 0xFFFFFFFE -> beat addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
REQ-043 rst_n=0 during beat 2 of a split SW -> next cycle IDLE, mem_we=0, req_ready=1, no resp_valid, bytes 2-3 unwritten.
REQ-044 req_valid held high through a 4-beat access -> second request accepted only at N+6, exactly one resp_valid per request.

Source files
------------

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: passes aligned accesses straight to the memory stage and
// splits misaligned half/word accesses into unsigned-byte beats, reassembling loads.
module lsu_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_mode,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_we,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_split,
    output logic [2:0]            mem_ls_mode,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam logic [2:0] B_MODE  = 3'b000;
    localparam logic [2:0] H_MODE  = 3'b001;
    localparam logic [2:0] W_MODE  = 3'b010;
    localparam logic [2:0] UB_MODE = 3'b100;
    localparam logic [2:0] UH_MODE = 3'b101;

    typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [2:0]              r_mode;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_we;
    logic                    r_split;
    logic [2:0]              r_nbeats;
    logic [1:0]              r_beat;
    logic [DATA_WIDTH-1:0]   r_asm;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_resp_split;

    logic                    w_handshake;
    logic                    w_req_mis;
    logic                    w_last;
    logic                    w_split_beat;
    logic [DATA_WIDTH-1:0]   w_asm;
    logic [7:0]              w_wbyte;

    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] lsb);
        case (mode)
            W_MODE:          is_misaligned = (lsb != 2'b00);
            H_MODE, UH_MODE: is_misaligned = lsb[0];
            default:         is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic mode_known(input logic [2:0] mode);
        case (mode)
            B_MODE, H_MODE, W_MODE, UB_MODE, UH_MODE: mode_known = 1'b1;
            default:                                  mode_known = 1'b0;
        endcase
    endfunction

    // Aligned loads arrive already extended by the memory stage; only split loads are extended here.
    function automatic logic [DATA_WIDTH-1:0] load_result(
        input logic                  we,
        input logic [2:0]            mode,
        input logic                  split,
        input logic [DATA_WIDTH-1:0] asm_data
    );
        if (we || !mode_known(mode)) begin
            load_result = '0;
        end else if (!split) begin
            load_result = asm_data;
        end else begin
            case (mode)
                H_MODE:  load_result = {{16{asm_data[15]}}, asm_data[15:0]};
                UH_MODE: load_result = {16'h0000, asm_data[15:0]};
                default: load_result = asm_data;
            endcase
        end
    endfunction

    assign w_handshake  = req_valid && req_ready;
    assign w_req_mis    = is_misaligned(req_mode, req_addr[1:0]);
    assign w_last       = ({1'b0, r_beat} == (r_nbeats - 3'd1));
    assign w_split_beat = (r_state == BEAT) && r_split;
    assign w_wbyte      = r_wdata[{r_beat, 3'b000} +: 8];

    assign req_ready   = (r_state == IDLE);
    assign resp_valid  = (r_state == RESP);
    assign resp_rdata  = r_rdata;
    assign resp_split  = r_resp_split;
    assign mem_ls_mode = w_split_beat ? UB_MODE : r_mode;
    assign mem_a       = w_split_beat ? (r_addr + {{(DATA_WIDTH-2){1'b0}}, r_beat}) : r_addr;
    assign mem_wd      = w_split_beat ? {4{w_wbyte}} : r_wdata;
    assign mem_we      = (r_state == BEAT) && r_we && mode_known(r_mode);

    always_comb begin
        w_asm = r_asm;
        if (r_split) begin
            w_asm[{r_beat, 3'b000} +: 8] = mem_rd[7:0];
        end else begin
            w_asm = mem_rd;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_handshake) w_next = BEAT;
            BEAT:    if (w_last) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_mode       <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_split      <= 1'b0;
            r_nbeats     <= '0;
            r_beat       <= '0;
            r_asm        <= '0;
            r_rdata      <= '0;
            r_resp_split <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_mode   <= req_mode;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_we     <= req_we;
                        r_split  <= w_req_mis;
                        r_beat   <= '0;
                        r_nbeats <= !w_req_mis ? 3'd1 : ((req_mode == W_MODE) ? 3'd4 : 3'd2);
                    end
                end
                BEAT: begin
                    r_asm <= w_asm;
                    if (w_last) begin
                        r_rdata      <= load_result(r_we, r_mode, r_split, w_asm);
                        r_resp_split <= r_split;
                    end else begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer with a byte-addressed memory model behind the mem_* port.
module tb_lsu_sequencer;

    localparam logic [2:0] B_MODE  = 3'b000;
    localparam logic [2:0] H_MODE  = 3'b001;
    localparam logic [2:0] W_MODE  = 3'b010;
    localparam logic [2:0] UB_MODE = 3'b100;
    localparam logic [2:0] UH_MODE = 3'b101;
    localparam logic [2:0] BAD_MODE = 3'b011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_split;
    logic [2:0]  mem_ls_mode;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    int total = 0;
    int bad = 0;

    logic [7:0] mem [0:4095];
    bit         loaded = 1'b0;

    int          nb;
    int          lat;
    logic [31:0] got_rdata;
    logic        got_split;
    logic [31:0] ba  [0:7];
    logic [31:0] bwd [0:7];
    logic [2:0]  bmd [0:7];
    logic        bwe [0:7];

    always #5 clk = ~clk;

    lsu_sequencer #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_split(resp_split),
        .mem_ls_mode(mem_ls_mode), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_rd(mem_rd)
    );

    // Memory model: 4 KiB mirrored over the address space, little-endian.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h100] <= 8'hEF; mem[12'h101] <= 8'hBE;
            mem[12'h102] <= 8'hAD; mem[12'h103] <= 8'hDE;
            mem[12'h303] <= 8'h80; mem[12'h304] <= 8'hFF;
            mem[12'hFFE] <= 8'h11; mem[12'hFFF] <= 8'h22;
            mem[12'h000] <= 8'h33; mem[12'h001] <= 8'h44;
            loaded <= 1'b1;
        end else if (mem_we) begin
            case (mem_ls_mode)
                B_MODE, UB_MODE: mem[mem_a[11:0]] <= mem_wd[7:0];
                H_MODE, UH_MODE: begin
                    mem[mem_a[11:0]]         <= mem_wd[7:0];
                    mem[mem_a[11:0] + 12'd1] <= mem_wd[15:8];
                end
                default: begin
                    mem[mem_a[11:0]]         <= mem_wd[7:0];
                    mem[mem_a[11:0] + 12'd1] <= mem_wd[15:8];
                    mem[mem_a[11:0] + 12'd2] <= mem_wd[23:16];
                    mem[mem_a[11:0] + 12'd3] <= mem_wd[31:24];
                end
            endcase
        end
    end

    always_comb begin
        case (mem_ls_mode)
            B_MODE:  mem_rd = {{24{mem[mem_a[11:0]][7]}}, mem[mem_a[11:0]]};
            UB_MODE: mem_rd = {24'h0, mem[mem_a[11:0]]};
            H_MODE:  mem_rd = {{16{mem[mem_a[11:0] + 12'd1][7]}}, mem[mem_a[11:0] + 12'd1], mem[mem_a[11:0]]};
            UH_MODE: mem_rd = {16'h0, mem[mem_a[11:0] + 12'd1], mem[mem_a[11:0]]};
            default: mem_rd = {mem[mem_a[11:0] + 12'd3], mem[mem_a[11:0] + 12'd2],
                               mem[mem_a[11:0] + 12'd1], mem[mem_a[11:0]]};
        endcase
    end

    // Issues one request and records every beat until resp_valid (lat = -1 on timeout).
    task automatic issue(input logic [2:0] mode, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic we);
        @(negedge clk);
        req_valid = 1'b1; req_mode = mode; req_addr = addr; req_wdata = wdata; req_we = we;
        @(posedge clk);
        nb = 0; lat = -1; got_rdata = 'x; got_split = 1'bx;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                lat = cyc; got_rdata = resp_rdata; got_split = resp_split;
                break;
            end
            if (nb < 8) begin
                ba[nb] = mem_a; bwd[nb] = mem_wd; bmd[nb] = mem_ls_mode; bwe[nb] = mem_we;
            end
            nb++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_mode = '0; req_addr = '0; req_wdata = '0; req_we = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", resp_rdata); end
        total++; if (resp_split !== 1'b0) begin bad++; $display("FAIL reset_split got=%b want=0", resp_split); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL reset_mem_a got=%h want=0", mem_a); end
        total++; if (mem_wd !== 32'h0) begin bad++; $display("FAIL reset_mem_wd got=%h want=0", mem_wd); end
        total++; if (mem_ls_mode !== 3'd0) begin bad++; $display("FAIL reset_mem_mode got=%h want=0", mem_ls_mode); end
        rst_n = 1'b1;
    endtask

    task automatic test_aligned_lw;
        issue(W_MODE, 32'h100, 32'h0, 1'b0);
        total++; if (nb !== 1) begin bad++; $display("FAIL alw_beats got=%0d want=1", nb); end
        total++; if (lat !== 2) begin bad++; $display("FAIL alw_latency got=%0d want=2", lat); end
        total++; if (ba[0] !== 32'h100) begin bad++; $display("FAIL alw_addr got=%h want=00000100", ba[0]); end
        total++; if (bmd[0] !== W_MODE) begin bad++; $display("FAIL alw_mode got=%h want=%h", bmd[0], W_MODE); end
        total++; if (got_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL alw_rdata got=%h want=deadbeef", got_rdata); end
        total++; if (got_split !== 1'b0) begin bad++; $display("FAIL alw_split got=%b want=0", got_split); end
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL alw_ready_after got=%b want=1", req_ready); end
        total++; if (resp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL alw_rdata_hold got=%h want=deadbeef", resp_rdata); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL alw_single_pulse got=%b want=0", resp_valid); end
    endtask

    task automatic test_split_sw_lw;
        logic [31:0] exp_wd [0:3];
        exp_wd[0] = 32'h44444444; exp_wd[1] = 32'h33333333;
        exp_wd[2] = 32'h22222222; exp_wd[3] = 32'h11111111;
        issue(W_MODE, 32'h201, 32'h11223344, 1'b1);
        total++; if (nb !== 4) begin bad++; $display("FAIL ssw_beats got=%0d want=4", nb); end
        total++; if (lat !== 5) begin bad++; $display("FAIL ssw_latency got=%0d want=5", lat); end
        for (int k = 0; k < 4; k++) begin
            total++; if (ba[k] !== 32'h201 + k) begin bad++; $display("FAIL ssw_addr%0d got=%h want=%h", k, ba[k], 32'h201 + k); end
            total++; if (bwd[k] !== exp_wd[k]) begin bad++; $display("FAIL ssw_wd%0d got=%h want=%h", k, bwd[k], exp_wd[k]); end
            total++; if (bmd[k] !== UB_MODE) begin bad++; $display("FAIL ssw_mode%0d got=%h want=%h", k, bmd[k], UB_MODE); end
            total++; if (bwe[k] !== 1'b1) begin bad++; $display("FAIL ssw_we%0d got=%b want=1", k, bwe[k]); end
        end
        total++; if (got_rdata !== 32'h0) begin bad++; $display("FAIL ssw_rdata got=%h want=0", got_rdata); end
        total++; if (got_split !== 1'b1) begin bad++; $display("FAIL ssw_split got=%b want=1", got_split); end
        issue(W_MODE, 32'h201, 32'h0, 1'b0);
        total++; if (nb !== 4) begin bad++; $display("FAIL slw_beats got=%0d want=4", nb); end
        total++; if (bwe[0] !== 1'b0) begin bad++; $display("FAIL slw_we got=%b want=0", bwe[0]); end
        total++; if (got_rdata !== 32'h11223344) begin bad++; $display("FAIL slw_rdata got=%h want=11223344", got_rdata); end
        total++; if (got_split !== 1'b1) begin bad++; $display("FAIL slw_split got=%b want=1", got_split); end
    endtask

    task automatic test_split_half;
        issue(H_MODE, 32'h303, 32'h0, 1'b0);
        total++; if (nb !== 2) begin bad++; $display("FAIL lh_beats got=%0d want=2", nb); end
        total++; if (ba[1] !== 32'h304) begin bad++; $display("FAIL lh_addr1 got=%h want=00000304", ba[1]); end
        total++; if (got_rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lh_rdata got=%h want=ffffff80", got_rdata); end
        issue(UH_MODE, 32'h303, 32'h0, 1'b0);
        total++; if (nb !== 2) begin bad++; $display("FAIL lhu_beats got=%0d want=2", nb); end
        total++; if (got_rdata !== 32'h0000FF80) begin bad++; $display("FAIL lhu_rdata got=%h want=0000ff80", got_rdata); end
        total++; if (got_split !== 1'b1) begin bad++; $display("FAIL lhu_split got=%b want=1", got_split); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_a [0:3];
        exp_a[0] = 32'hFFFFFFFE; exp_a[1] = 32'hFFFFFFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
        issue(W_MODE, 32'hFFFFFFFE, 32'h0, 1'b0);
        total++; if (nb !== 4) begin bad++; $display("FAIL wrap_beats got=%0d want=4", nb); end
        for (int k = 0; k < 4; k++) begin
            total++; if (ba[k] !== exp_a[k]) begin bad++; $display("FAIL wrap_addr%0d got=%h want=%h", k, ba[k], exp_a[k]); end
        end
        total++; if (got_rdata !== 32'h44332211) begin bad++; $display("FAIL wrap_rdata got=%h want=44332211", got_rdata); end
    endtask

    task automatic test_bad_mode;
        issue(BAD_MODE, 32'h100, 32'h12345678, 1'b1);
        total++; if (nb !== 1) begin bad++; $display("FAIL bad_beats got=%0d want=1", nb); end
        total++; if (bwe[0] !== 1'b0) begin bad++; $display("FAIL bad_we got=%b want=0", bwe[0]); end
        total++; if (got_rdata !== 32'h0) begin bad++; $display("FAIL bad_rdata got=%h want=0", got_rdata); end
        total++; if (mem[12'h100] !== 8'hEF) begin bad++; $display("FAIL bad_mem got=%h want=ef", mem[12'h100]); end
    endtask

    task automatic test_reset_mid;
        int nresp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_mode = W_MODE; req_addr = 32'h401; req_wdata = 32'hAABBCCDD; req_we = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", req_ready); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmid_mem_we got=%b want=0", mem_we); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rmid_resp got=%b want=0", resp_valid); end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        total++; if (nresp !== 0) begin bad++; $display("FAIL rmid_no_resp got=%0d want=0", nresp); end
        total++; if (mem[12'h401] !== 8'hDD) begin bad++; $display("FAIL rmid_b0 got=%h want=dd", mem[12'h401]); end
        total++; if (mem[12'h402] !== 8'hCC) begin bad++; $display("FAIL rmid_b1 got=%h want=cc", mem[12'h402]); end
        total++; if (mem[12'h403] !== 8'h00) begin bad++; $display("FAIL rmid_b2 got=%h want=00", mem[12'h403]); end
        total++; if (mem[12'h404] !== 8'h00) begin bad++; $display("FAIL rmid_b3 got=%h want=00", mem[12'h404]); end
    endtask

    task automatic test_back_to_back;
        int second = -1;
        int nresp = 0;
        int r0 = -1;
        int r1 = -1;
        @(negedge clk);
        req_valid = 1'b1; req_mode = W_MODE; req_addr = 32'h201; req_wdata = 32'h0; req_we = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (second >= 0 && cyc == second + 1) req_valid = 1'b0;
            if (resp_valid) begin
                if (nresp == 0) r0 = cyc; else r1 = cyc;
                nresp++;
            end
            if (req_ready && second < 0) second = cyc;
        end
        req_valid = 1'b0;
        total++; if (second !== 6) begin bad++; $display("FAIL b2b_accept got=%0d want=6", second); end
        total++; if (nresp !== 2) begin bad++; $display("FAIL b2b_nresp got=%0d want=2", nresp); end
        total++; if (r0 !== 5) begin bad++; $display("FAIL b2b_resp0 got=%0d want=5", r0); end
        total++; if (r1 !== 11) begin bad++; $display("FAIL b2b_resp1 got=%0d want=11", r1); end
    endtask

    initial begin
        test_reset();
        test_aligned_lw();
        test_split_sw_lw();
        test_split_half();
        test_wrap();
        test_bad_mode();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
